// File: rtl/wb_trace_buffer.sv
// Write-back retirement trace buffer: captures register writes into a
// FWFT FIFO and streams them out; drops (and counts) when full.
module wb_trace_buffer #(
  parameter int DEPTH   = 16,
  parameter bit SKIP_R0 = 1'b1
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [31:0]                debug_wb_pc,
  input  logic [3:0]                 debug_wb_rf_we,
  input  logic [4:0]                 debug_wb_rf_wnum,
  input  logic [31:0]                debug_wb_rf_wdata,
  input  logic                       flush,
  output logic                       trace_valid,
  input  logic                       trace_ready,
  output logic [31:0]                trace_pc,
  output logic [3:0]                 trace_we,
  output logic [4:0]                 trace_wnum,
  output logic [31:0]                trace_wdata,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic                       overflow,
  output logic [31:0]                capture_cnt,
  output logic [15:0]                drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  we;
    logic [4:0]  wnum;
    logic [31:0] wdata;
  } rec_t;

  rec_t          mem [DEPTH];
  rec_t          head;
  rec_t          in_rec;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          cap;
  logic          pop;
  logic          full;
  logic          push;
  logic          drop;

  assign cap  = (|debug_wb_rf_we) &&
                !(SKIP_R0 && debug_wb_rf_wnum == 5'd0);
  assign full = (fifo_count == CW'(DEPTH));
  assign trace_valid = (fifo_count != '0);
  assign pop  = trace_valid && trace_ready;
  assign push = cap && (!full || pop);
  assign drop = cap && full && !pop;

  assign in_rec = '{pc:    debug_wb_pc,
                    we:    debug_wb_rf_we,
                    wnum:  debug_wb_rf_wnum,
                    wdata: debug_wb_rf_wdata};

  assign head        = mem[rd_ptr];
  assign trace_pc    = head.pc;
  assign trace_we    = head.we;
  assign trace_wnum  = head.wnum;
  assign trace_wdata = head.wdata;

  // A full push-with-pop overwrites the head slot, which is read before the edge.
  always_ff @(posedge clk) begin
    if (resetn && !flush && push)
      mem[wr_ptr] <= in_rec;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      fifo_count  <= '0;
      overflow    <= 1'b0;
      capture_cnt <= '0;
      drop_cnt    <= '0;
    end else if (flush) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr      <= wr_ptr + AW'(1);
        capture_cnt <= capture_cnt + 32'd1;
      end
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)
        fifo_count <= fifo_count + CW'(1);
      else if (pop && !push)
        fifo_count <= fifo_count - CW'(1);
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != 16'hFFFF)
          drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end

endmodule
